// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues word requests to instruction
// memory and buffers returned instructions with their PCs for the decoder.
module inst_fetch #(
    parameter int                XLEN            = 32,
    parameter logic [XLEN-1:0]   RESET_PC        = '0,
    parameter int                FIFO_DEPTH      = 4,
    parameter int                MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            o_mem_req,
    output logic [XLEN-1:0] o_mem_addr,
    input  logic            i_mem_gnt,
    input  logic            i_mem_rvalid,
    input  logic [31:0]     i_mem_rdata,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_halt,
    output logic            o_inst_valid,
    input  logic            i_inst_ready,
    output logic [31:0]     o_inst,
    output logic [XLEN-1:0] o_pc,
    output logic            o_flush_pipe
);

    // state | meaning
    // BOOT  | first cycle after reset release, no request
    // RUN   | issuing fetch requests subject to credit
    // HALT  | no new requests; in-flight responses still delivered
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc;
    logic [OW-1:0]   outstanding, outstanding_nxt, discard_cnt;
    logic [CW-1:0]   fifo_count;
    logic [FW-1:0]   fifo_rd, fifo_wr;
    logic [31:0]     fifo_inst [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc   [FIFO_DEPTH];
    logic [XLEN-1:0] aq_mem    [MAX_OUTSTANDING];
    logic [AW-1:0]   aq_rd, aq_wr;
    logic            mem_req, grant, fifo_push, fifo_pop, flush_q;

    function automatic logic [AW-1:0] aq_next(input logic [AW-1:0] idx);
        return (idx == AW'(MAX_OUTSTANDING - 1)) ? '0 : idx + AW'(1);
    endfunction

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                if (i_halt) state_nxt = HALT;
                // Credit rule: every granted request already owns a FIFO slot.
                mem_req = !i_redirect
                          && (int'(outstanding) < MAX_OUTSTANDING)
                          && ((int'(outstanding) + int'(fifo_count)) < FIFO_DEPTH);
            end
            HALT: if (!i_halt) state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    assign grant     = mem_req & i_mem_gnt;
    assign fifo_push = i_mem_rvalid & (discard_cnt == '0) & ~i_redirect;
    assign fifo_pop  = o_inst_valid & i_inst_ready;

    always_comb begin
        outstanding_nxt = outstanding;
        if (grant && !i_mem_rvalid)
            outstanding_nxt = outstanding + OW'(1);
        else if (!grant && i_mem_rvalid)
            outstanding_nxt = outstanding - OW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
            fifo_count  <= '0;
            fifo_rd     <= '0;
            fifo_wr     <= '0;
            aq_rd       <= '0;
            aq_wr       <= '0;
            flush_q     <= 1'b0;
        end else begin
            state       <= state_nxt;
            flush_q     <= i_redirect;
            outstanding <= outstanding_nxt;
            if (i_redirect) begin
                // Everything still in flight becomes stale and is dropped on return.
                pc          <= i_redirect_pc & ALIGN_MASK;
                discard_cnt <= outstanding_nxt;
                fifo_count  <= '0;
                fifo_rd     <= '0;
                fifo_wr     <= '0;
                aq_rd       <= '0;
                aq_wr       <= '0;
            end else begin
                if (grant) begin
                    pc    <= pc + XLEN'(4);
                    aq_wr <= aq_next(aq_wr);
                end
                if (i_mem_rvalid) begin
                    if (discard_cnt != '0) discard_cnt <= discard_cnt - OW'(1);
                    else                   aq_rd       <= aq_next(aq_rd);
                end
                if (fifo_push) fifo_wr <= fifo_wr + FW'(1);
                if (fifo_pop)  fifo_rd <= fifo_rd + FW'(1);
                if (fifo_push && !fifo_pop)
                    fifo_count <= fifo_count + CW'(1);
                else if (!fifo_push && fifo_pop)
                    fifo_count <= fifo_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant) aq_mem[aq_wr] <= pc;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_inst[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else if (fifo_push) begin
            fifo_inst[fifo_wr] <= i_mem_rdata;
            fifo_pc[fifo_wr]   <= aq_mem[aq_rd];
        end
    end

    assign o_mem_req    = mem_req;
    assign o_mem_addr   = pc;
    assign o_inst_valid = (fifo_count != '0);
    assign o_inst       = fifo_inst[fifo_rd];
    assign o_pc         = fifo_pc[fifo_rd];
    assign o_flush_pipe = flush_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: a transaction-level model (queues of in-flight
// requests and buffered instructions) is compared against the DUT every cycle.
module tb_inst_fetch;

    localparam int MAXO  = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_gnt = 1'b0;
    logic        i_mem_rvalid = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        i_halt = 1'b0;
    logic        o_inst_valid;
    logic        i_inst_ready = 1'b0;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        o_flush_pipe;

    inst_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .o_mem_req     (o_mem_req),
        .o_mem_addr    (o_mem_addr),
        .i_mem_gnt     (i_mem_gnt),
        .i_mem_rvalid  (i_mem_rvalid),
        .i_mem_rdata   (i_mem_rdata),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_halt        (i_halt),
        .o_inst_valid  (o_inst_valid),
        .i_inst_ready  (i_inst_ready),
        .o_inst        (o_inst),
        .o_pc          (o_pc),
        .o_flush_pipe  (o_flush_pipe)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; bit stale; } ob_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } fe_t;
    typedef struct { logic [31:0] addr; int due; } mp_t;
    typedef enum { M_BOOT, M_RUN, M_HALT } mode_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gnt_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1;
    bit halt_k = 1'b0, rst_k = 1'b0;

    mode_t       m_mode = M_BOOT;
    logic [31:0] m_pc = '0;
    ob_t         m_out[$];
    fe_t         m_fifo[$];
    mp_t         mem_q[$];
    bit          m_flush = 1'b0, m_known = 1'b0, m_pristine = 1'b1;
    logic [31:0] log_pc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_and_step();
        bit  exp_req, grant, pop;
        ob_t r;
        fe_t e;
        exp_req = (m_mode == M_RUN) && !i_redirect && (m_out.size() < MAXO)
                  && ((m_out.size() + m_fifo.size()) < DEPTH);
        if (m_known) begin
            chk("mem_req", 32'(o_mem_req), 32'(exp_req));
            chk("mem_addr", o_mem_addr, m_pc);
            chk("inst_valid", 32'(o_inst_valid), 32'(m_fifo.size() != 0));
            if (m_fifo.size() != 0) begin
                chk("inst", o_inst, m_fifo[0].inst);
                chk("pc", o_pc, m_fifo[0].pc);
            end else if (m_pristine) begin
                chk("inst_rst", o_inst, 32'h0);
                chk("pc_rst", o_pc, 32'h0);
            end
            chk("flush", 32'(o_flush_pipe), 32'(m_flush));
        end
        if (o_inst_valid && i_inst_ready) log_pc.push_back(o_pc);
        if (!rst) begin
            m_mode = M_BOOT; m_pc = 32'h0; m_flush = 1'b0; m_pristine = 1'b1;
            m_out.delete(); m_fifo.delete(); mem_q.delete();
            m_known = 1'b1;
            return;
        end
        grant = exp_req && i_mem_gnt;
        pop   = (m_fifo.size() != 0) && i_inst_ready;
        r     = '{32'h0, 1'b1};
        if (i_mem_rvalid && m_out.size() != 0) r = m_out.pop_front();
        if (i_redirect) begin
            m_pc = i_redirect_pc & 32'hFFFF_FFFC;
            foreach (m_out[i]) m_out[i].stale = 1'b1;
            m_fifo.delete();
        end else begin
            if (pop) void'(m_fifo.pop_front());
            if (i_mem_rvalid && !r.stale) begin
                e.pc = r.addr; e.inst = i_mem_rdata;
                m_fifo.push_back(e);
                m_pristine = 1'b0;
            end
            if (grant) begin
                m_out.push_back('{m_pc, 1'b0});
                mem_q.push_back('{m_pc, cyc + int'($urandom_range(lat_max, lat_min))});
                m_pc = m_pc + 32'd4;
            end
        end
        m_flush = i_redirect;
        case (m_mode)
            M_BOOT: m_mode = M_RUN;
            M_RUN:  if (i_halt) m_mode = M_HALT;
            M_HALT: if (!i_halt) m_mode = M_RUN;
            default: m_mode = M_BOOT;
        endcase
    endtask

    task automatic cycle(input bit redir = 1'b0, input logic [31:0] rpc = 32'h0);
        @(posedge clk);
        #1;
        cyc++;
        rst           = rst_k;
        i_mem_gnt     = ($urandom_range(99) < gnt_pct);
        i_inst_ready  = ($urandom_range(99) < rdy_pct);
        i_halt        = halt_k;
        i_redirect    = redir;
        i_redirect_pc = rpc;
        if (rst_k && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = mem_q[0].addr ^ 32'hA5A5_0000;
            void'(mem_q.pop_front());
        end else begin
            i_mem_rvalid = 1'b0;
            i_mem_rdata  = $urandom;
        end
        @(negedge clk);
        check_and_step();
    endtask

    function automatic int seq_breaks();
        int bad = 0;
        for (int i = 1; i < log_pc.size(); i++)
            if (log_pc[i] != log_pc[i-1] + 32'd4) bad++;
        return bad;
    endfunction

    initial begin
        int          n0;
        bit          found;
        logic [31:0] p0;

        // Reset with grant held high
        rst_k = 1'b0;
        repeat (5) cycle();
        chk("rst_req", 32'(o_mem_req), 32'h0);
        chk("rst_valid", 32'(o_inst_valid), 32'h0);
        chk("rst_addr", o_mem_addr, 32'h0);
        log_pc.delete();
        rst_k = 1'b1;
        cycle();
        chk("boot_no_req", 32'(o_mem_req), 32'h0);
        cycle();
        chk("first_req", 32'(o_mem_req), 32'h1);
        chk("first_addr", o_mem_addr, 32'h0);

        // Streaming, 1-cycle memory, decoder always ready
        repeat (30) cycle();
        chk("stream_pc0", log_pc[0], 32'h0);
        chk("stream_pc1", log_pc[1], 32'h4);
        chk("stream_pc2", log_pc[2], 32'h8);
        n0 = log_pc.size();
        repeat (20) cycle();
        chk("throughput", 32'(log_pc.size() - n0), 32'd20);

        // Back-pressure
        rdy_pct = 0;
        repeat (2) cycle();
        p0 = o_pc;
        repeat (8) cycle();
        chk("bp_hold_pc", o_pc, p0);
        chk("bp_no_req", 32'(o_mem_req), 32'h0);
        chk("bp_valid", 32'(o_inst_valid), 32'h1);
        rdy_pct = 100;
        repeat (20) cycle();
        chk("bp_seq", 32'(seq_breaks()), 32'h0);

        // Redirect with two outstanding
        lat_min = 2; lat_max = 2;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_out.size() == 2) found = 1'b1;
            else cycle();
        end
        chk("redir_setup", 32'(found), 32'h1);
        cycle(1'b1, 32'h0000_0103);
        log_pc.delete();
        cycle();
        chk("redir_flush", 32'(o_flush_pipe), 32'h1);
        chk("redir_valid", 32'(o_inst_valid), 32'h0);
        chk("redir_addr", o_mem_addr, 32'h100);
        cycle();
        chk("redir_flush_end", 32'(o_flush_pipe), 32'h0);
        for (int i = 0; i < 20 && log_pc.size() == 0; i++) cycle();
        chk("redir_first_pc", (log_pc.size() != 0) ? log_pc[0] : 32'hDEAD_BEEF, 32'h100);

        // Redirect while a response lands in the same cycle
        lat_min = 1; lat_max = 1;
        repeat (6) cycle();
        cycle(1'b1, 32'h0000_0200);
        log_pc.delete();
        for (int i = 0; i < 20 && log_pc.size() == 0; i++) cycle();
        chk("same_cyc_first_pc", (log_pc.size() != 0) ? log_pc[0] : 32'hDEAD_BEEF, 32'h200);

        // Wrap, then halt and resume
        cycle(1'b1, 32'hFFFF_FFF8);
        log_pc.delete();
        repeat (10) cycle();
        chk("wrap_pc0", log_pc[0], 32'hFFFF_FFF8);
        chk("wrap_pc1", log_pc[1], 32'hFFFF_FFFC);
        chk("wrap_pc2", log_pc[2], 32'h0);
        halt_k = 1'b1;
        repeat (3) cycle();
        chk("halt_no_req", 32'(o_mem_req), 32'h0);
        repeat (5) cycle();
        chk("halt_drained", 32'(o_inst_valid), 32'h0);
        halt_k = 1'b0;
        repeat (12) cycle();
        chk("halt_seq", 32'(seq_breaks()), 32'h0);

        // Randomized traffic with redirects, halts and a mid-run reset
        gnt_pct = 70; rdy_pct = 60; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) rst_k = 1'b0;
            if (i == 1503) rst_k = 1'b1;
            if ($urandom_range(99) < 5) halt_k = ~halt_k;
            if ($urandom_range(99) < 4) cycle(1'b1, $urandom);
            else cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
